// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FIFO sizing and threshold defaults for the I2C controller
package i2c_pkg;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_AF_THRESH  = 6;
  localparam int FIFO_AE_THRESH  = 1;
endpackage

// File: rtl/i2c_fifo_mem.sv
// i2c_fifo_mem: simple dual-port RAM, one synchronous write port, one asynchronous read port
module i2c_fifo_mem
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  // storage array, intentionally without reset
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/i2c_sync_fifo.sv
// i2c_sync_fifo: single-clock byte FIFO with fill level, thresholds, sticky errors and optional FWFT
module i2c_sync_fifo
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = FIFO_AF_THRESH,
  parameter int AE_THRESH  = FIFO_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  write_full,
  output logic                  read_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] L_AF    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] L_AE    = (ADDR_WIDTH+1)'(AE_THRESH);
  logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr, r_fill, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_mem_q;
  logic                  r_rvalid, r_ovf, r_unf, w_full, w_empty, w_wr_acc, w_rd_acc;
  assign w_full       = r_fill == L_DEPTH;
  assign w_empty      = r_fill == '0;
  assign w_wr_acc     = !clear && write_enable && !w_full;
  assign w_rd_acc     = !clear && read_enable && !w_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + (ADDR_WIDTH+1)'(w_wr_acc);
  assign w_rd_ptr_nxt = r_rd_ptr + (ADDR_WIDTH+1)'(w_rd_acc);
  i2c_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata (write_data),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_mem_q)
  );
  // pointers and registered fill level; clear flushes without touching memory
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_fill   <= w_wr_ptr_nxt - w_rd_ptr_nxt;
    end
  // sticky rejected-access flags, cleared only by clear or reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (clear) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (write_enable & w_full);
      r_unf <= r_unf | (read_enable & w_empty);
    end
  // registered read path; the data register survives clear, the valid pulse does not
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) r_rdata <= w_mem_q;
    end
  assign read_data    = (FWFT != 0) ? (w_empty ? '0 : w_mem_q) : r_rdata;
  assign read_valid   = (FWFT != 0) ? !w_empty : r_rvalid;
  assign write_full   = w_full;
  assign read_empty   = w_empty;
  assign almost_full  = r_fill >= L_AF;
  assign almost_empty = r_fill <= L_AE;
  assign fill_level   = r_fill;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
endmodule

// File: tb/tb_i2c_sync_fifo.sv
// tb_i2c_sync_fifo: table vectors, corner sequences and random traffic against a queue model
module tb_i2c_sync_fifo;
  logic       clk = 1'b0;
  logic       reset, clear, we, re;
  logic [7:0] wd;
  logic [7:0] rd [2];
  logic [3:0] lvl [2];
  logic [1:0] rv, full, empty, af, ae, ovf, unf;
  int n_tests = 0;
  int n_fail = 0;
  byte unsigned q[$];
  logic [7:0] m_rd;
  bit m_rv, m_ovf, m_unf;
  typedef struct {
    logic we; logic [7:0] wd; logic re; logic cl;
    logic [3:0] lvl; logic full; logic empty; logic ovf; logic unf; logic rv; logic [7:0] rd;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  i2c_sync_fifo #(.FWFT(0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .write_enable(we), .write_data(wd),
    .read_enable(re), .read_data(rd[0]), .read_valid(rv[0]), .write_full(full[0]),
    .read_empty(empty[0]), .almost_full(af[0]), .almost_empty(ae[0]), .fill_level(lvl[0]),
    .overflow(ovf[0]), .underflow(unf[0]));

  i2c_sync_fifo #(.FWFT(1)) dut_f (
    .clk(clk), .reset(reset), .clear(clear), .write_enable(we), .write_data(wd),
    .read_enable(re), .read_data(rd[1]), .read_valid(rv[1]), .write_full(full[1]),
    .read_empty(empty[1]), .almost_full(af[1]), .almost_empty(ae[1]), .fill_level(lvl[1]),
    .overflow(ovf[1]), .underflow(unf[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [7:0] d, input logic r, input logic c,
                              input int l, input logic f, input logic e, input logic o,
                              input logic u, input logic v, input logic [7:0] x);
    vec_t t;
    t.we = w; t.wd = d; t.re = r; t.cl = c; t.lvl = 4'(l); t.full = f; t.empty = e;
    t.ovf = o; t.unf = u; t.rv = v; t.rd = x;
    return t;
  endfunction

  task automatic model_reset();
    q.delete();
    m_rd = '0; m_rv = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_edge();
    bit f, e;
    if (clear) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0;
    end else begin
      f = q.size() == 8;
      e = q.size() == 0;
      m_rv = re && !e;
      if (re && !e) m_rd = q.pop_front();
      if (we && !f) q.push_back(wd);
      if (we && f) m_ovf = 1;
      if (re && e) m_unf = 1;
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s/d%0d lvl", tag, d), 32'(lvl[d]), 32'(n));
      chk($sformatf("%s/d%0d full", tag, d), 32'(full[d]), 32'(n == 8));
      chk($sformatf("%s/d%0d empty", tag, d), 32'(empty[d]), 32'(n == 0));
      chk($sformatf("%s/d%0d af", tag, d), 32'(af[d]), 32'(n >= 6));
      chk($sformatf("%s/d%0d ae", tag, d), 32'(ae[d]), 32'(n <= 1));
      chk($sformatf("%s/d%0d ovf", tag, d), 32'(ovf[d]), 32'(m_ovf));
      chk($sformatf("%s/d%0d unf", tag, d), 32'(unf[d]), 32'(m_unf));
      chk($sformatf("%s/d%0d rv", tag, d), 32'(rv[d]), d == 0 ? 32'(m_rv) : 32'(n != 0));
      chk($sformatf("%s/d%0d rd", tag, d), 32'(rd[d]), d == 0 ? 32'(m_rd) : (n != 0 ? 32'(q[0]) : 32'h0));
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c, input string tag);
    we = w; wd = d; re = r; clear = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; clear = 0; we = 0; re = 0; wd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(1, 8'(i), 0, 0, i < 8 ? i + 1 : 8, i >= 7, 0, i == 8, 0, 0, 8'h00));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 8'h00, 1, 0, 7 - i, 0, i == 7, 1, 0, 1, 8'(i)));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 1, 0, 8'h07));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 0, 8'h07));
    foreach (tbl[k]) begin
      step(tbl[k].we, tbl[k].wd, tbl[k].re, tbl[k].cl, $sformatf("tbl%0d", k));
      chk($sformatf("vec%0d lvl", k), 32'(lvl[0]), 32'(tbl[k].lvl));
      chk($sformatf("vec%0d full", k), 32'(full[0]), 32'(tbl[k].full));
      chk($sformatf("vec%0d empty", k), 32'(empty[0]), 32'(tbl[k].empty));
      chk($sformatf("vec%0d ovf", k), 32'(ovf[0]), 32'(tbl[k].ovf));
      chk($sformatf("vec%0d unf", k), 32'(unf[0]), 32'(tbl[k].unf));
      chk($sformatf("vec%0d rv", k), 32'(rv[0]), 32'(tbl[k].rv));
      chk($sformatf("vec%0d rd", k), 32'(rd[0]), 32'(tbl[k].rd));
    end

    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0, "mid_fill");
    step(1, 8'h14, 1, 0, "mid_rw");
    chk("rw_at_4 lvl", 32'(lvl[0]), 32'd4);
    chk("rw_at_4 data", 32'(rd[0]), 32'h10);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, "mid_drain");
    chk("rw_at_4 last", 32'(rd[0]), 32'h14);

    for (int i = 0; i < 8; i++) step(1, 8'(8'h20 + i), 0, 0, "full_fill");
    step(1, 8'h99, 1, 0, "full_rw");
    chk("rw_full lvl", 32'(lvl[0]), 32'd7);
    chk("rw_full ovf", 32'(ovf[0]), 32'd1);
    step(0, 8'h00, 0, 1, "clr");
    step(1, 8'h55, 1, 0, "empty_rw");
    chk("rw_empty lvl", 32'(lvl[0]), 32'd1);
    chk("rw_empty unf", 32'(unf[0]), 32'd1);
    step(0, 8'h00, 0, 1, "clr");

    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + p * 8 + i), 0, 0, "wrap_w");
      for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, "wrap_r");
    end
    step(1, 8'h77, 1, 0, "wrap_rw");
    step(1, 8'h78, 1, 0, "wrap_rw");
    step(0, 8'h00, 0, 1, "clr");

    step(1, 8'hA5, 0, 0, "fwft_w");
    chk("fwft rd", 32'(rd[1]), 32'hA5);
    chk("fwft rv", 32'(rv[1]), 32'd1);
    step(0, 8'h00, 1, 0, "fwft_unf");
    step(0, 8'h00, 1, 0, "fwft_unf");
    step(1, 8'h3C, 0, 1, "fwft_clr");
    chk("clr lvl", 32'(lvl[1]), 32'd0);
    chk("clr unf", 32'(unf[1]), 32'd0);
    chk("clr ovf", 32'(ovf[1]), 32'd0);

    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, 0, "pre_rst");
    step(0, 8'h00, 1, 0, "pre_rst");
    we = 0; re = 0; clear = 0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst lvl", 32'(lvl[0]), 32'd0);
    chk("async_rst rd", 32'(rd[0]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 800; i++) begin
      int bias;
      bias = ((i / 40) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < bias, 8'($urandom), $urandom_range(0, 99) < 100 - bias,
           $urandom_range(0, 99) < 2, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
